vol_ctrl: RTL and testbench

Mixer volume configuration controller. Receives per-channel target gains over a SPI config port and holds them in a register file. Once per audio frame it sweeps all entries and ramps the live gain toward its target, so gain changes do not produce zipper noise. Drives the flat `vol` vector consumed by `mixer`, replacing the hard-wired gain constant.

---
 rtl/dmix_cfg_pkg.sv | 35 +++
 rtl/vol_ctrl_if.sv | 14 +
 rtl/spi_cfg_slave.sv | 99 +++++++++
 rtl/vol_ctrl.sv | 120 ++++++++++++
 tb/tb_vol_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dmix_cfg_pkg.sv
// Shared mixer-configuration constants, SPI frame layout and the gain ramp
// step used by the volume controller.
package dmix_cfg_pkg;

   localparam int unsigned VOL_W          = 16;
   localparam int unsigned ADDR_W         = 7;
   localparam int unsigned SPI_FRAME_BITS = 24;
   localparam int unsigned CNT_W          = 5;

   localparam int unsigned FRM_W_BIT   = 23;
   localparam int unsigned FRM_ADDR_HI = 22;
   localparam int unsigned FRM_ADDR_LO = 16;

   typedef enum logic {
      RAMP_IDLE,
      RAMP_SWEEP
   } ramp_state_e;

   // Difference is formed before the step so the result never wraps.
   function automatic logic [VOL_W-1:0] ramp_step(input logic [VOL_W-1:0] cur,
                                                  input logic [VOL_W-1:0] tgt,
                                                  input logic [VOL_W-1:0] step);
      logic [VOL_W-1:0] diff;
      diff      = '0;
      ramp_step = cur;
      if (cur < tgt) begin
         diff      = tgt - cur;
         ramp_step = (diff > step) ? cur + step : tgt;
      end else if (cur > tgt) begin
         diff      = cur - tgt;
         ramp_step = (diff > step) ? cur - step : tgt;
      end
   endfunction

endpackage

// File: rtl/vol_ctrl_if.sv
// SPI configuration port of the volume controller (mode 0, MSB first).
interface vol_ctrl_if;

   logic spi_sclk_i;
   logic spi_cs_n_i;
   logic spi_mosi_i;
   logic spi_miso_o;

   modport master (output spi_sclk_i, output spi_cs_n_i, output spi_mosi_i,
                   input spi_miso_o);
   modport slave  (input spi_sclk_i, input spi_cs_n_i, input spi_mosi_i,
                   output spi_miso_o);

endinterface

// File: rtl/spi_cfg_slave.sv
// SPI config slave: pin synchronisers, 24-bit shifter, write strobe and
// read-data shift-out for the gain register file.
module spi_cfg_slave
   import dmix_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   vol_ctrl_if.slave         spi,
   output logic              wr_stb_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [VOL_W-1:0]  wr_data_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [VOL_W-1:0]  rd_data_i
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPI_FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPI_FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_RDLD = CNT_W'(SPI_FRAME_BITS - VOL_W - 1);
   localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(SPI_FRAME_BITS - VOL_W);

   logic [2:0]                sclk_q;
   logic [2:0]                cs_q;
   logic [1:0]                mosi_q;
   logic                      sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
   logic                      active_q, wr_stb_q, ld_pend_q, rd_act_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [SPI_FRAME_BITS-1:0] shift_q;
   logic [VOL_W-1:0]          sr_out_q;

   // cs_n stages reset low so a select held low across reset is never seen
   // as a fresh falling edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_q <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], spi.spi_sclk_i};
         cs_q   <= {cs_q[1:0], spi.spi_cs_n_i};
         mosi_q <= {mosi_q[0], spi.spi_mosi_i};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign mosi_s    = mosi_q[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q  <= 1'b0;
         cnt_q     <= '0;
         shift_q   <= '0;
         wr_stb_q  <= 1'b0;
         ld_pend_q <= 1'b0;
         rd_act_q  <= 1'b0;
         sr_out_q  <= '0;
      end else begin
         wr_stb_q  <= 1'b0;
         ld_pend_q <= 1'b0;
         if (cs_fall) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            shift_q  <= '0;
            rd_act_q <= 1'b0;
         end else if (cs_rise) begin
            active_q <= 1'b0;
            rd_act_q <= 1'b0;
         end else if (active_q) begin
            if (sclk_rise && (cnt_q < CNT_FULL)) begin
               shift_q   <= {shift_q[SPI_FRAME_BITS-2:0], mosi_s};
               cnt_q     <= cnt_q + 1'b1;
               wr_stb_q  <= (cnt_q == CNT_LAST);
               ld_pend_q <= (cnt_q == CNT_RDLD);
            end
            if (ld_pend_q && !shift_q[FRM_W_BIT-VOL_W]) begin
               sr_out_q <= rd_data_i;
               rd_act_q <= 1'b1;
            end
            // The fall right after the header leaves bit 15 for the next rise.
            if (sclk_fall && rd_act_q && (cnt_q > CNT_HDR)) begin
               if (cnt_q == CNT_FULL) begin
                  rd_act_q <= 1'b0;
               end else begin
                  sr_out_q <= {sr_out_q[VOL_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign wr_stb_o       = wr_stb_q & shift_q[FRM_W_BIT];
   assign wr_addr_o      = shift_q[FRM_ADDR_HI:FRM_ADDR_LO];
   assign wr_data_o      = shift_q[VOL_W-1:0];
   assign rd_addr_o      = shift_q[FRM_ADDR_HI-VOL_W:FRM_ADDR_LO-VOL_W];
   assign spi.spi_miso_o = rd_act_q & sr_out_q[VOL_W-1];

endmodule

// File: rtl/vol_ctrl.sv
// Mixer volume controller: SPI-written target gains, ramped once per audio
// frame into the live gain vector feeding the mixer.
module vol_ctrl
   import dmix_cfg_pkg::*;
#(
   parameter int unsigned      NUM_CH   = 1,
   parameter logic [VOL_W-1:0] VOL_INIT = 16'h00ff,
   parameter logic [VOL_W-1:0] STEP     = 16'h0004
) (
   input  logic                      clk,
   input  logic                      rst,
   vol_ctrl_if.slave                 spi,
   input  logic                      frame_i,
   output logic [NUM_CH*2*VOL_W-1:0] vol_o,
   output logic                      busy_o
);

   localparam int unsigned NUM_ENT = 2 * NUM_CH;
   localparam int unsigned IDX_W   = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENT - 1);

   logic [VOL_W-1:0]  tgt_q [NUM_ENT];
   logic [VOL_W-1:0]  cur_q [NUM_ENT];

   logic              wr_stb, wr_ok, rd_ok;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [VOL_W-1:0]  wr_data, rd_data, cur_nxt;
   logic [IDX_W-1:0]  wr_idx, rd_idx;

   ramp_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              pend_q, pend_d;
   logic              sweep_en;

   spi_cfg_slave u_spi (
      .clk       (clk),
      .rst       (rst),
      .spi       (spi),
      .wr_stb_o  (wr_stb),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data),
      .rd_addr_o (rd_addr),
      .rd_data_i (rd_data)
   );

   assign wr_ok   = wr_stb && (32'(wr_addr) < NUM_ENT);
   assign wr_idx  = wr_addr[IDX_W-1:0];
   assign rd_ok   = (32'(rd_addr) < NUM_ENT);
   assign rd_idx  = rd_addr[IDX_W-1:0];
   assign rd_data = rd_ok ? tgt_q[rd_idx] : '0;

   assign cur_nxt = ramp_step(cur_q[idx_q], tgt_q[idx_q], STEP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_ENT; i++) begin
            tgt_q[i] <= VOL_INIT;
            cur_q[i] <= VOL_INIT;
         end
      end else begin
         if (wr_ok) begin
            tgt_q[wr_idx] <= wr_data;
         end
         if (sweep_en) begin
            cur_q[idx_q] <= cur_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RAMP_IDLE;
         idx_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
      end
   end

   // Frames arriving mid-sweep collapse into a single pending request.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pend_d   = pend_q;
      sweep_en = 1'b0;
      unique case (state_q)
         RAMP_IDLE: begin
            if (frame_i || pend_q) begin
               state_d = RAMP_SWEEP;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         RAMP_SWEEP: begin
            sweep_en = 1'b1;
            if (frame_i) begin
               pend_d = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
               state_d = RAMP_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = RAMP_IDLE;
      endcase
   end

   always_comb begin
      vol_o = '0;
      for (int unsigned i = 0; i < NUM_ENT; i++) begin
         vol_o[VOL_W*i +: VOL_W] = cur_q[i];
      end
   end

   assign busy_o = (state_q == RAMP_SWEEP);

endmodule

// File: tb/tb_vol_ctrl.sv
// Randomised self-checking bench for vol_ctrl with a per-frame gain model.
module tb_vol_ctrl;

   localparam int NUM_CH = 2;
   localparam int N      = 2 * NUM_CH;
   localparam int STEPV  = 4;
   localparam int HALF   = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_i;
   logic [63:0]   vol_o;
   logic          busy_o;

   int            n_err = 0;
   int            n_chk = 0;
   int            tgt_m [N];
   int            cur_m [N];

   always #5 clk = ~clk;

   vol_ctrl_if spi_if ();

   vol_ctrl #(
      .NUM_CH   (NUM_CH),
      .VOL_INIT (16'h00ff),
      .STEP     (16'h0004)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .spi     (spi_if),
      .frame_i (frame_i),
      .vol_o   (vol_o),
      .busy_o  (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Move toward the target by at most STEPV, never past it.
   function automatic int ramp_model(input int c, input int t);
      int d;
      d = t - c;
      if (d > STEPV) d = STEPV;
      if (d < -STEPV) d = -STEPV;
      return c + d;
   endfunction

   function automatic logic [63:0] pack_vol(input int v [N]);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[16*k +: 16] = 16'(v[k]);
      return r;
   endfunction

   task automatic spi_frame(input logic [23:0] word, input int nbits, output logic [15:0] rd);
      rd = '0;
      @(negedge clk) spi_if.spi_cs_n_i = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_if.spi_mosi_i = word[23-i];
         repeat (HALF) @(negedge clk);
         if (i >= 8 && i < 24) rd[23-i] = spi_if.spi_miso_o;
         spi_if.spi_sclk_i = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_if.spi_sclk_i = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      spi_if.spi_cs_n_i = 1'b1;
      spi_if.spi_mosi_i = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic spi_write(input logic [6:0] addr, input logic [15:0] data);
      logic [15:0] dummy;
      spi_frame({1'b1, addr, data}, 24, dummy);
      if (int'(addr) < N) tgt_m[int'(addr)] = int'(data);
   endtask

   task automatic spi_read(input string tag, input logic [6:0] addr);
      logic [15:0] rd;
      int          exp;
      spi_frame({1'b0, addr, 16'h0000}, 24, rd);
      exp = (int'(addr) < N) ? tgt_m[int'(addr)] : 0;
      check(tag, 64'(rd), 64'(exp));
      check("miso_idle", 64'(spi_if.spi_miso_o), 64'd0);
   endtask

   // One frame pulse; entry k must change exactly one cycle after entry k-1.
   task automatic do_frame();
      int old_v [N];
      int new_v [N];
      int exp_v [N];
      for (int k = 0; k < N; k++) begin
         old_v[k] = cur_m[k];
         new_v[k] = ramp_model(cur_m[k], tgt_m[k]);
      end
      @(negedge clk) frame_i = 1'b1;
      for (int i = 1; i <= N + 1; i++) begin
         @(negedge clk) frame_i = 1'b0;
         for (int k = 0; k < N; k++) exp_v[k] = (k < i - 1) ? new_v[k] : old_v[k];
         check("ramp_vol", vol_o, pack_vol(exp_v));
         check("ramp_busy", 64'(busy_o), 64'(i <= N));
      end
      for (int k = 0; k < N; k++) cur_m[k] = new_v[k];
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] dummy;
      logic [6:0]  a;
      logic [15:0] d;
      int          r;
      int          exp_busy [10];

      rst               = 1'b0;
      frame_i           = 1'b0;
      spi_if.spi_sclk_i = 1'b0;
      spi_if.spi_cs_n_i = 1'b1;
      spi_if.spi_mosi_i = 1'b0;
      for (int k = 0; k < N; k++) begin
         tgt_m[k] = 16'h00ff;
         cur_m[k] = 16'h00ff;
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      check("reset_vol", vol_o, {4{16'h00ff}});
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_miso", 64'(spi_if.spi_miso_o), 64'd0);

      // Target below live gain on entry 1: ramps down by STEP per frame.
      spi_write(7'd1, 16'h0010);
      repeat (3) do_frame();
      check("down_e1", 64'(vol_o[31:16]), 64'h00f3);

      // Ramp up on entry 0 and hold at the target.
      spi_write(7'd0, 16'h0107);
      do_frame();
      check("up_first", 64'(vol_o[15:0]), 64'h0103);
      do_frame();
      check("up_second", 64'(vol_o[15:0]), 64'h0107);
      do_frame();
      check("up_hold", 64'(vol_o[15:0]), 64'h0107);

      // Bring entry 2 to 2, then target 0: clamps without wrap.
      spi_write(7'd2, 16'h0002);
      repeat (64) do_frame();
      check("at_two", 64'(vol_o[47:32]), 64'h0002);
      spi_write(7'd2, 16'h0000);
      do_frame();
      check("down_clamp", 64'(vol_o[47:32]), 64'h0000);

      // Read-back and out-of-range accesses.
      spi_write(7'd1, 16'hbeef);
      spi_read("read_e1", 7'd1);
      check("read_beef", 64'(tgt_m[1]), 64'hbeef);
      spi_read("read_oor", 7'h7f);
      spi_write(7'h7f, 16'h1234);
      for (int k = 0; k < N; k++) spi_read("read_after_oor", 7'(k));
      do_frame();

      // Aborted write leaves the target alone; next frame writes.
      spi_frame({1'b1, 7'd3, 16'h5a5a}, 20, dummy);
      spi_read("abort_keep", 7'd3);
      spi_write(7'd3, 16'h5a5a);
      spi_read("after_abort", 7'd3);
      do_frame();

      // Back-to-back frame pulses at t, t+2 and t+3: one queued sweep.
      exp_busy = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      @(negedge clk) frame_i = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk) frame_i = (i == 2 || i == 3);
         check("b2b_busy", 64'(busy_o), 64'(exp_busy[i-1]));
      end
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < N; k++) cur_m[k] = ramp_model(cur_m[k], tgt_m[k]);
      check("b2b_vol", vol_o, pack_vol(cur_m));

      // Random mix of writes, reads and frames.
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            a = ($urandom_range(0, 7) == 0) ? 7'h7f : 7'($urandom_range(0, N + 1));
            if ($urandom_range(0, 1) == 1) begin
               d = 16'($urandom);
            end else begin
               d = 16'((int'(a) < N ? cur_m[int'(a)] : 0) + $urandom_range(0, 24) - 12);
            end
            spi_write(a, d);
         end else if (r < 7) begin
            spi_read("rand_read", 7'($urandom_range(0, N + 2)));
         end
         repeat ($urandom_range(1, 3)) do_frame();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
